// File: rtl/chip_checker_pkg.sv
// Shared definitions for the chip-checker front end: sequencer states and default sizing.
package chip_checker_pkg;

    localparam int unsigned N_CHIPS        = 8;
    localparam int unsigned TIMEOUT_CYCLES = 1024;
    localparam int unsigned SETTLE_CYCLES  = 2;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        CAPTURE,
        RELEASE
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping; synchronous clear wins over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge Clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/chip_test_sequencer.sv
// Launches one tester on a start pulse, waits for a settled Done, latches its verdict
// and releases the tester with DISP_RSLT; keeps saturating pass/fail tallies.
module chip_test_sequencer #(
    parameter int unsigned N_CHIPS        = chip_checker_pkg::N_CHIPS,
    parameter int unsigned SEL_W          = 3,
    parameter int unsigned TIMEOUT_CYCLES = chip_checker_pkg::TIMEOUT_CYCLES,
    parameter int unsigned SETTLE_CYCLES  = chip_checker_pkg::SETTLE_CYCLES,
    parameter int unsigned CNT_W          = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [SEL_W-1:0]   Sel,
    input  logic [N_CHIPS-1:0] Done,
    input  logic [N_CHIPS-1:0] RSLT,
    output logic [N_CHIPS-1:0] Run,
    output logic               DISP_RSLT,
    output logic               Busy,
    output logic               Valid,
    output logic               Pass,
    output logic               Timeout,
    output logic               BadSel,
    output logic [CNT_W-1:0]   PassCount,
    output logic [CNT_W-1:0]   FailCount
);

    import chip_checker_pkg::*;

    localparam int unsigned IDX_W = (N_CHIPS > 1) ? $clog2(N_CHIPS) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned ST_W  = $clog2(SETTLE_CYCLES + 1);

    state_t            state;
    logic [IDX_W-1:0]  sel_q;
    logic [TO_W-1:0]   to_cnt;
    logic [ST_W-1:0]   settle_cnt;

    logic sel_ok;
    logic done_sel;
    logic rslt_sel;
    logic settled;
    logic to_expired;
    logic pass_inc;
    logic fail_inc;

    assign sel_ok     = (32'(Sel) < N_CHIPS);
    assign done_sel   = Done[sel_q];
    assign rslt_sel   = RSLT[sel_q];
    assign settled    = done_sel && (settle_cnt == ST_W'(SETTLE_CYCLES - 1));
    assign to_expired = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Tally strobes line up with the edge that latches the matching verdict.
    always_comb begin
        pass_inc = 1'b0;
        fail_inc = 1'b0;
        case (state)
            IDLE:      fail_inc = Start && !sel_ok;
            WAIT_DONE: fail_inc = !settled && to_expired;
            CAPTURE: begin
                pass_inc = rslt_sel;
                fail_inc = !rslt_sel;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            sel_q      <= '0;
            to_cnt     <= '0;
            settle_cnt <= '0;
            Run        <= '0;
            DISP_RSLT  <= 1'b0;
            Busy       <= 1'b0;
            Valid      <= 1'b0;
            Pass       <= 1'b0;
            Timeout    <= 1'b0;
            BadSel     <= 1'b0;
        end else begin
            Run <= '0;
            case (state)
                IDLE: begin
                    if (Start && sel_ok) begin
                        sel_q   <= IDX_W'(Sel);
                        Run     <= N_CHIPS'(1) << IDX_W'(Sel);
                        Busy    <= 1'b1;
                        Valid   <= 1'b0;
                        Pass    <= 1'b0;
                        Timeout <= 1'b0;
                        BadSel  <= 1'b0;
                        state   <= LAUNCH;
                    end else if (Start) begin
                        Valid   <= 1'b1;
                        Pass    <= 1'b0;
                        Timeout <= 1'b0;
                        BadSel  <= 1'b1;
                    end
                end
                LAUNCH: begin
                    to_cnt     <= '0;
                    settle_cnt <= '0;
                    state      <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (settled) begin
                        state <= CAPTURE;
                    end else if (to_expired) begin
                        Timeout   <= 1'b1;
                        Valid     <= 1'b1;
                        Pass      <= 1'b0;
                        DISP_RSLT <= 1'b1;
                        to_cnt    <= '0;
                        state     <= RELEASE;
                    end else begin
                        to_cnt     <= to_cnt + TO_W'(1);
                        settle_cnt <= done_sel ? settle_cnt + ST_W'(1) : '0;
                    end
                end
                CAPTURE: begin
                    Pass      <= rslt_sel;
                    Valid     <= 1'b1;
                    DISP_RSLT <= 1'b1;
                    to_cnt    <= '0;
                    state     <= RELEASE;
                end
                RELEASE: begin
                    // A tester that never drops Done is abandoned with the verdict kept.
                    if (!done_sel || to_expired) begin
                        DISP_RSLT <= 1'b0;
                        Busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_pass_cnt (
        .Clk   (Clk),
        .clr   (Reset),
        .inc   (pass_inc),
        .count (PassCount)
    );

    sat_counter #(.WIDTH(CNT_W)) u_fail_cnt (
        .Clk   (Clk),
        .clr   (Reset),
        .inc   (fail_inc),
        .count (FailCount)
    );

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Directed bench for chip_test_sequencer; verdicts are queued at launch and compared when latched.
module tb_chip_test_sequencer;

    localparam int unsigned N  = 8;
    localparam int unsigned SW = 4;

    logic           Clk;
    logic           Reset;
    logic           Start;
    logic [SW-1:0]  Sel;
    logic [N-1:0]   Done;
    logic [N-1:0]   RSLT;
    logic [N-1:0]   Run;
    logic           DISP_RSLT;
    logic           Busy;
    logic           Valid;
    logic           Pass;
    logic           Timeout;
    logic           BadSel;
    logic [7:0]     PassCount;
    logic [7:0]     FailCount;

    typedef struct packed {
        logic       pass;
        logic       timeout;
        logic       badsel;
        logic       disp;
        logic [7:0] pc;
        logic [7:0] fc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_pc = 8'd0;
    logic [7:0] exp_fc = 8'd0;

    chip_test_sequencer #(
        .N_CHIPS        (N),
        .SEL_W          (SW),
        .TIMEOUT_CYCLES (1024),
        .SETTLE_CYCLES  (2),
        .CNT_W          (8)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Sel       (Sel),
        .Done      (Done),
        .RSLT      (RSLT),
        .Run       (Run),
        .DISP_RSLT (DISP_RSLT),
        .Busy      (Busy),
        .Valid     (Valid),
        .Pass      (Pass),
        .Timeout   (Timeout),
        .BadSel    (BadSel),
        .PassCount (PassCount),
        .FailCount (FailCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bump_pass();
        if (exp_pc != 8'hFF) exp_pc = exp_pc + 8'd1;
    endtask

    task automatic bump_fail();
        if (exp_fc != 8'hFF) exp_fc = exp_fc + 8'd1;
    endtask

    task automatic push_exp(input logic p, input logic t, input logic b, input logic d);
        exp_t e;
        e.pass = p; e.timeout = t; e.badsel = b; e.disp = d;
        e.pc = exp_pc; e.fc = exp_fc;
        sb.push_back(e);
    endtask

    task automatic check_verdict(input string tag);
        exp_t e;
        chk({tag, "_sb_pending"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_valid"},   32'(Valid),     32'd1);
            chk({tag, "_pass"},    32'(Pass),      32'(e.pass));
            chk({tag, "_timeout"}, 32'(Timeout),   32'(e.timeout));
            chk({tag, "_badsel"},  32'(BadSel),    32'(e.badsel));
            chk({tag, "_disp"},    32'(DISP_RSLT), 32'(e.disp));
            chk({tag, "_passcnt"}, 32'(PassCount), 32'(e.pc));
            chk({tag, "_failcnt"}, 32'(FailCount), 32'(e.fc));
        end
    endtask

    // Full tester handshake: Done raised `delay` cycles after launch, held `hold` cycles past the verdict.
    task automatic run_chip(input int sel, input logic res, input int delay, input int hold, input string tag);
        int lat;
        if (res) bump_pass(); else bump_fail();
        push_exp(res, 1'b0, 1'b0, 1'b1);
        Sel   = SW'(sel);
        RSLT  = res ? N'(1 << sel) : ~N'(1 << sel);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk({tag, "_run_onehot"}, 32'(Run), 32'(1 << sel));
        chk({tag, "_busy"}, 32'(Busy), 32'd1);
        chk({tag, "_valid_cleared"}, 32'(Valid), 32'd0);
        repeat (delay) @(negedge Clk);
        chk({tag, "_run_dropped"}, 32'(Run), 32'd0);
        Done = N'(1 << sel);
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
        end while (Valid !== 1'b1 && lat < 50);
        chk({tag, "_latency"}, 32'(lat), 32'd3);
        check_verdict(tag);
        repeat (hold) begin
            @(negedge Clk);
            chk({tag, "_disp_held"}, 32'(DISP_RSLT), 32'd1);
        end
        Done = '0;
        @(negedge Clk);
        chk({tag, "_disp_fall"}, 32'(DISP_RSLT), 32'd0);
        chk({tag, "_idle"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        int lat;
        Reset = 1'b1;
        Start = 1'b0;
        Sel   = '0;
        Done  = '0;
        RSLT  = '0;
        repeat (2) @(negedge Clk);
        chk("rst_run",  32'(Run),       32'd0);
        chk("rst_disp", 32'(DISP_RSLT), 32'd0);
        chk("rst_busy", 32'(Busy),      32'd0);
        chk("rst_valid", 32'(Valid),    32'd0);
        chk("rst_pc",   32'(PassCount), 32'd0);
        chk("rst_fc",   32'(FailCount), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // Passing and failing runs on chip 2
        run_chip(2, 1'b1, 5, 3, "t1");
        run_chip(2, 1'b0, 5, 1, "t2");

        // Chip 5 never answers; an unselected Done must not help it
        bump_fail();
        push_exp(1'b0, 1'b1, 1'b0, 1'b1);
        Sel = 4'd5; RSLT = 8'hFF; Done = 8'h01; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("t3_run_onehot", 32'(Run), 32'h20);
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
        end while (Valid !== 1'b1 && lat < 1100);
        chk("t3_timeout_latency", 32'(lat), 32'd1025);
        check_verdict("t3");
        @(negedge Clk);
        chk("t3_disp_fall", 32'(DISP_RSLT), 32'd0);
        chk("t3_idle", 32'(Busy), 32'd0);
        Done = '0;

        // Out-of-range select is rejected without launching
        bump_fail();
        push_exp(1'b0, 1'b0, 1'b1, 1'b0);
        Sel = 4'd9; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check_verdict("t4");
        chk("t4_no_run", 32'(Run), 32'd0);
        chk("t4_not_busy", 32'(Busy), 32'd0);
        @(negedge Clk);
        chk("t4_no_run_late", 32'(Run), 32'd0);
        chk("t4_not_busy_late", 32'(Busy), 32'd0);

        // Glitch on Done[3] and a Start while busy are both ignored
        bump_pass();
        push_exp(1'b1, 1'b0, 1'b0, 1'b1);
        Sel = 4'd3; RSLT = 8'h08; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("t5_run_onehot", 32'(Run), 32'h08);
        @(negedge Clk);
        Done = 8'h08; Sel = 4'd1; Start = 1'b1;
        @(negedge Clk);
        Done = '0; Start = 1'b0;
        chk("t5_restart_ignored", 32'(Run), 32'd0);
        @(negedge Clk);
        chk("t5_no_glitch_capture_a", 32'(Valid), 32'd0);
        @(negedge Clk);
        chk("t5_no_glitch_capture_b", 32'(Valid), 32'd0);
        Done = 8'h08;
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
        end while (Valid !== 1'b1 && lat < 50);
        chk("t5_latency", 32'(lat), 32'd3);
        check_verdict("t5");
        Done = '0;
        @(negedge Clk);
        chk("t5_idle", 32'(Busy), 32'd0);

        // Reset in the middle of a wait clears everything
        Sel = 4'd0; RSLT = 8'h01; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        exp_pc = 8'd0;
        exp_fc = 8'd0;
        chk("t6_rst_run",     32'(Run),       32'd0);
        chk("t6_rst_disp",    32'(DISP_RSLT), 32'd0);
        chk("t6_rst_busy",    32'(Busy),      32'd0);
        chk("t6_rst_valid",   32'(Valid),     32'd0);
        chk("t6_rst_pass",    32'(Pass),      32'd0);
        chk("t6_rst_timeout", 32'(Timeout),   32'd0);
        chk("t6_rst_badsel",  32'(BadSel),    32'd0);
        chk("t6_rst_pc",      32'(PassCount), 32'd0);
        chk("t6_rst_fc",      32'(FailCount), 32'd0);
        @(negedge Clk);

        // Fill the pass tally to its ceiling, then one more pass must hold it
        for (int i = 0; i < 255; i++) run_chip(1, 1'b1, 1, 0, "t6_fill");
        chk("t6_pc_full", 32'(PassCount), 32'd255);
        run_chip(1, 1'b1, 1, 1, "t6_sat");
        chk("t6_pc_sat", 32'(PassCount), 32'd255);
        chk("t6_fc_zero", 32'(FailCount), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chip_test_sequencer.md
# chip_test_sequencer

Front-end controller for the chip-checker testers. Latches the operator's chip selection on a start pulse and asserts `Run` to exactly one tester. It then waits for that tester's `Done`, samples its `RSLT` once stable, and returns the tester to its halted state by pulsing `DISP_RSLT`. The latched verdict, timeout flag and saturating pass/fail tallies drive the board's LED/hex display logic.

## Interface

**Parameters**
- `N_CHIPS`, 8: number of tester instances attached; sets the width of the `run`, `done` and `rslt` vectors.
- `SEL_W`, 3: width of `Sel`; must satisfy 2^`SEL_W` ≥ `N_CHIPS`.
- `TIMEOUT_CYCLES`, 1024: maximum cycles spent in `WAIT_DONE` before the run is aborted.
- `SETTLE_CYCLES`, 2: consecutive cycles `Done` must be high before `RSLT` is sampled.
- `CNT_W`, 8: width of the pass/fail tallies.

**Ports**
- `Clk` in 1: system clock; all state changes on its rising edge.
- `Reset` in 1: synchronous, active-high.
- `Start` in 1: single-cycle start pulse, already synchronised and edge-detected upstream.
- `Sel` in `SEL_W`: chip index; sampled only on an accepted `Start`.
- `Done` in `N_CHIPS`: per-tester `Done`.
- `RSLT` in `N_CHIPS`: per-tester `RSLT`.
- `Run` out `N_CHIPS`: one-hot run request to the testers.
- `DISP_RSLT` out 1: broadcast release to the testers.
- `Busy` out 1: high in every state except `IDLE`.
- `Valid` out 1: a verdict is latched and displayable.
- `Pass` out 1: the latched verdict was a pass.
- `Timeout` out 1: the latched run was aborted by timeout.
- `BadSel` out 1: the latched run was rejected because `Sel` ≥ `N_CHIPS`.
- `PassCount` out `CNT_W`: saturating count of passes.
- `FailCount` out `CNT_W`: saturating count of fails, timeouts and bad selects.

## Operation

**Reset values.** Every output is 0 after reset, including both counters. All internal registers and the state (`IDLE`) are also cleared. Asserting `Reset` in the middle of a run drops `Run`/`DISP_RSLT` on the next edge. The tester is not explicitly released; it receives its own `Reset` from the same source.

**States**
- `IDLE`
  - On `Start` with `Sel` < `N_CHIPS`: latch `Sel`, clear `Valid`/`Pass`/`Timeout`/`BadSel`, go to `LAUNCH`.
  - On `Start` with `Sel` ≥ `N_CHIPS`: set `Valid`=1, `BadSel`=1, `Pass`=0, increment `FailCount`, stay in `IDLE`.
- `LAUNCH`: `Run[sel]`=1 for exactly one cycle, then go to `WAIT_DONE`. The timeout counter is cleared on entry.
- `WAIT_DONE`
  - While `Done[sel]`=1: increment the settle counter. When it reaches `SETTLE_CYCLES`, go to `CAPTURE`.
  - `Done[sel]`=0 resets the settle counter to 0.
  - When the timeout counter reaches `TIMEOUT_CYCLES`-1: set `Timeout`=1, `Valid`=1, `Pass`=0, increment `FailCount`, go to `RELEASE`.
- `CAPTURE`: set `Pass`=`RSLT[sel]`, `Valid`=1, increment `PassCount` or `FailCount`, go to `RELEASE`.
- `RELEASE`: `DISP_RSLT`=1. Stay until `Done[sel]`=0 (observed on the same edge), then return to `IDLE`. This state is also bounded by `TIMEOUT_CYCLES`; on expiry, return to `IDLE` with the verdict unchanged.

**Rules**
- `Start` in any state other than `IDLE` is ignored.
- `Sel` changes while `Busy` are ignored.
- `Done`/`RSLT` bits of unselected chips are ignored.
- Counters saturate at 2^`CNT_W`-1 with no wrap.
- The timeout counter is sized `$clog2(TIMEOUT_CYCLES)+1`.
- `Run` is never multi-hot.
- `Valid` and the verdict flags persist until the next accepted `Start` or `Reset`.

## Timing

- `Start` at edge k: `Run[sel]` is high during cycle k+1 only.
- Latency from `Done[sel]` rising to `Valid`: `SETTLE_CYCLES`+1 edges.
- `DISP_RSLT` rises on the same edge as `Valid`. It falls on the edge after `Done[sel]` is sampled low, so the minimum pulse is 1 cycle.
- A back-to-back `Start` is accepted on the first cycle back in `IDLE`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- Shared package `chip_checker_pkg`: the state enum typedef (`IDLE`, `LAUNCH`, `WAIT_DONE`, `CAPTURE`, `RELEASE`) and the default constants `N_CHIPS`, `TIMEOUT_CYCLES`, `SETTLE_CYCLES`.
- One natural sub-module: `sat_counter` (parameterised width, increment enable, synchronous clear), instantiated twice for `PassCount` and `FailCount`.

## Test plan

1. Reset, then `Sel`=2, `Start`. Tester model raises `Done[2]` 5 cycles later with `RSLT[2]`=1.
   - Required: `Run`=8'b0000_0100 for one cycle; `Valid`=1 and `Pass`=1 three edges after `Done` rises; `PassCount`=1; `DISP_RSLT` high until `Done[2]` falls.
2. Same as 1 but `RSLT[2]`=0.
   - Required: `Pass`=0; `FailCount`=1; `PassCount` unchanged.
3. `Sel`=5, `Done` held at 0.
   - Required: `Timeout`=1 and `Valid`=1 after 1024 cycles in `WAIT_DONE`; `FailCount`+1; `DISP_RSLT` asserted; return to `IDLE`.
4. `Sel`=9 with `SEL_W`=4 and `N_CHIPS`=8.
   - Required: no `Run` pulse; `BadSel`=1; `Valid`=1; `FailCount`=1; `Busy` stays 0.
5. `Done[3]` glitches high for 1 cycle, then goes low, then high steadily; `Start` pulsed again while `Busy`.
   - Required: no capture from the glitch; capture only after 2 consecutive high cycles; the second `Start` has no effect.
6. `Reset` asserted during `WAIT_DONE`, and counters preloaded to 255 before a further pass.
   - Required: after reset, all outputs are 0 the next cycle. With a counter at 255, a further pass leaves `PassCount`=255.
